// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl
//   Scans a HUB75 LED panel using binary-coded modulation. For every row and
//   bit plane the controller fetches COLS pixel-plane words from an external
//   memory, shifts them into the panel, latches them, and then enables the
//   LEDs for BASE_OE << plane cycles. Planes run 0..PLANES-1 within a row and
//   rows run 0..ROWS-1 within a frame.
//
// Ports
//   clk, reset           : clock, asynchronous active-high reset
//   enable               : scanning permitted; checked only between DISPLAY
//                          phases, so a running shift/latch/display completes
//   rd_en, rd_row,
//   rd_col, rd_plane     : pixel-plane read request
//   rd_data              : {r0,g0,b0,r1,g1,b1}, valid one cycle after rd_en
//   hub75_clk, hub75_lat,
//   hub75_oe_, hub75_row : panel shift clock, latch, active-low enable, row
//   hub75_r0..hub75_b1   : panel serial data (upper and lower half)
//   frame_done           : one-cycle pulse after the last DISPLAY of a frame
//
// All outputs come straight from flops. The output flops are loaded from the
// *next* state/counter values so that each output lines up with the cycle
// the FSM is actually in.

module hub75_scan_ctrl #(
  parameter int COLS     = 64,
  parameter int ROW_BITS = 3,
  parameter int PLANES   = 8,
  parameter int BASE_OE  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  output logic                        rd_en,
  output logic [ROW_BITS-1:0]         rd_row,
  output logic [$clog2(COLS)-1:0]     rd_col,
  output logic [$clog2(PLANES)-1:0]   rd_plane,
  input  logic [5:0]                  rd_data,
  output logic                        hub75_clk,
  output logic                        hub75_lat,
  output logic                        hub75_oe_,
  output logic [ROW_BITS-1:0]         hub75_row,
  output logic                        hub75_r0,
  output logic                        hub75_g0,
  output logic                        hub75_b0,
  output logic                        hub75_r1,
  output logic                        hub75_g1,
  output logic                        hub75_b1,
  output logic                        frame_done
);

  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PLANES);
  // Shift cycle index runs 0 .. 2*COLS+1
  localparam int NW = CW + 2;
  // Display down-counter must hold BASE_OE << (PLANES-1)
  localparam int DW = $clog2(BASE_OE) + PLANES;

  localparam logic [NW-1:0]       SHIFT_LAST = NW'(2 * COLS + 1);
  localparam logic [NW-1:0]       FETCH_END  = NW'(2 * COLS);
  localparam logic [PW-1:0]       LAST_PLANE = PW'(PLANES - 1);
  localparam logic [ROW_BITS-1:0] LAST_ROW   = '1;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

  state_t              state_q, state_d;
  logic [NW-1:0]       cnt_q, cnt_d;
  logic [DW-1:0]       dcnt_q, dcnt_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [PW-1:0]       plane_q, plane_d;

  logic                rd_en_q, rd_en_d;
  logic [ROW_BITS-1:0] rd_row_q, rd_row_d;
  logic [CW-1:0]       rd_col_q, rd_col_d;
  logic [PW-1:0]       rd_plane_q, rd_plane_d;
  logic                sclk_q, sclk_d;
  logic                lat_q, lat_d;
  logic                oe_n_q, oe_n_d;
  logic [ROW_BITS-1:0] prow_q, prow_d;
  logic [5:0]          data_q, data_d;
  logic                frame_done_q, frame_done_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dcnt_d       = dcnt_q;
    row_d        = row_q;
    plane_d      = plane_q;
    data_d       = data_q;
    prow_d       = prow_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (cnt_q == SHIFT_LAST) begin
          state_d = LATCH;
        end else begin
          cnt_d = cnt_q + NW'(1);
        end
      end
      LATCH: begin
        state_d = DISPLAY;
        dcnt_d  = (DW'(BASE_OE) << plane_q) - DW'(1);
      end
      DISPLAY: begin
        if (dcnt_q == '0) begin
          if (plane_q == LAST_PLANE) begin
            plane_d = '0;
            row_d   = row_q + ROW_BITS'(1);
            if (row_q == LAST_ROW) begin
              frame_done_d = 1'b1;
            end
          end else begin
            plane_d = plane_q + PW'(1);
          end
          state_d = enable ? SHIFT : IDLE;
          cnt_d   = '0;
        end else begin
          dcnt_d = dcnt_q - DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // rd_data for column c arrives during shift cycle 2c+1; capture it so it
    // is on the panel pins for cycles 2c+2 and 2c+3.
    if (state_q == SHIFT && cnt_q[0] && cnt_q < SHIFT_LAST) begin
      data_d = rd_data;
    end

    if (state_d == LATCH) begin
      prow_d = row_q;
    end

    rd_en_d    = (state_d == SHIFT) && !cnt_d[0] && (cnt_d < FETCH_END);
    rd_col_d   = rd_en_d ? cnt_d[CW:1] : '0;
    rd_row_d   = row_d;
    rd_plane_d = plane_d;
    // Panel clock is high in the second cycle of each data pair (odd index >= 3)
    sclk_d     = (state_d == SHIFT) && cnt_d[0] && (cnt_d != NW'(1));
    lat_d      = (state_d == LATCH);
    oe_n_d     = (state_d != DISPLAY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dcnt_q       <= '0;
      row_q        <= '0;
      plane_q      <= '0;
      rd_en_q      <= 1'b0;
      rd_row_q     <= '0;
      rd_col_q     <= '0;
      rd_plane_q   <= '0;
      sclk_q       <= 1'b0;
      lat_q        <= 1'b0;
      oe_n_q       <= 1'b1;
      prow_q       <= '0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dcnt_q       <= dcnt_d;
      row_q        <= row_d;
      plane_q      <= plane_d;
      rd_en_q      <= rd_en_d;
      rd_row_q     <= rd_row_d;
      rd_col_q     <= rd_col_d;
      rd_plane_q   <= rd_plane_d;
      sclk_q       <= sclk_d;
      lat_q        <= lat_d;
      oe_n_q       <= oe_n_d;
      prow_q       <= prow_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_row     = rd_row_q;
  assign rd_col     = rd_col_q;
  assign rd_plane   = rd_plane_q;
  assign hub75_clk  = sclk_q;
  assign hub75_lat  = lat_q;
  assign hub75_oe_  = oe_n_q;
  assign hub75_row  = prow_q;
  assign hub75_r0   = data_q[5];
  assign hub75_g0   = data_q[4];
  assign hub75_b0   = data_q[3];
  assign hub75_r1   = data_q[2];
  assign hub75_g1   = data_q[1];
  assign hub75_b1   = data_q[0];
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// tb_hub75_scan_ctrl
//   Directed bench for hub75_scan_ctrl at default parameters. A negedge
//   monitor models the panel: it shifts the six data lines on every rising
//   hub75_clk, snapshots them on hub75_lat, and records hub75_oe_ low widths.

module tb_hub75_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       rd_en;
  logic [2:0] rd_row;
  logic [5:0] rd_col;
  logic [2:0] rd_plane;
  logic [5:0] rd_data;
  logic       hub75_clk, hub75_lat, hub75_oe_;
  logic [2:0] hub75_row;
  logic       hub75_r0, hub75_g0, hub75_b0, hub75_r1, hub75_g1, hub75_b1;
  logic       frame_done;

  int total = 0;
  int bad   = 0;

  hub75_scan_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .rd_en      (rd_en),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_plane   (rd_plane),
    .rd_data    (rd_data),
    .hub75_clk  (hub75_clk),
    .hub75_lat  (hub75_lat),
    .hub75_oe_  (hub75_oe_),
    .hub75_row  (hub75_row),
    .hub75_r0   (hub75_r0),
    .hub75_g0   (hub75_g0),
    .hub75_b0   (hub75_b0),
    .hub75_r1   (hub75_r1),
    .hub75_g1   (hub75_g1),
    .hub75_b1   (hub75_b1),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Panel model and statistics, sampled mid-cycle
  logic [5:0][63:0] sr;
  logic [5:0][63:0] lt;
  logic [5:0]       pv;
  logic             prev_sclk = 1'b0;
  int               oe_run = 0;
  int               widths[$];
  int               lat_cnt = 0;
  int               rd_en_cnt = 0;
  int               rises = 0;
  int               lat_rises = 0;
  logic [2:0]       last_lat_row = '0;

  always @(negedge clk) begin
    if (reset) begin
      oe_run    = 0;
      prev_sclk = 1'b0;
      rises     = 0;
    end else begin
      pv = {hub75_r0, hub75_g0, hub75_b0, hub75_r1, hub75_g1, hub75_b1};
      if (!hub75_oe_) oe_run++;
      else if (oe_run != 0) begin
        widths.push_back(oe_run);
        oe_run = 0;
      end
      if (hub75_clk && !prev_sclk) begin
        for (int i = 0; i < 6; i++) sr[i] = {sr[i][62:0], pv[i]};
        rises++;
      end
      prev_sclk = hub75_clk;
      if (hub75_lat) begin
        lat_cnt++;
        lt           = sr;
        lat_rises    = rises;
        rises        = 0;
        last_lat_row = hub75_row;
      end
      if (rd_en) rd_en_cnt++;
    end
  end

  task automatic clear_stats();
    widths.delete();
    lat_cnt   = 0;
    rd_en_cnt = 0;
  endtask

  task automatic run_n(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Reset, then release with the given enable; the first sample after this
  // returns is shift cycle 0 when enable=1.
  task automatic start_run(input logic en);
    reset   = 1'b1;
    enable  = en;
    rd_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    clear_stats();
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    enable  = 1'b1;
    rd_data = 6'h3f;
    run_n(3);
    pv = {hub75_r0, hub75_g0, hub75_b0, hub75_r1, hub75_g1, hub75_b1};
    total++; if (hub75_oe_ !== 1'b1) begin bad++; $display("FAIL reset_oe: got %b want 1", hub75_oe_); end
    total++; if (hub75_clk !== 1'b0) begin bad++; $display("FAIL reset_sclk: got %b want 0", hub75_clk); end
    total++; if (hub75_lat !== 1'b0) begin bad++; $display("FAIL reset_lat: got %b want 0", hub75_lat); end
    total++; if (hub75_row !== 3'd0) begin bad++; $display("FAIL reset_row: got %0d want 0", hub75_row); end
    total++; if (pv !== 6'd0) begin bad++; $display("FAIL reset_data: got %b want 000000", pv); end
    total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
    total++; if (rd_row !== 3'd0) begin bad++; $display("FAIL reset_rd_row: got %0d want 0", rd_row); end
    total++; if (rd_col !== 6'd0) begin bad++; $display("FAIL reset_rd_col: got %0d want 0", rd_col); end
    total++; if (rd_plane !== 3'd0) begin bad++; $display("FAIL reset_rd_plane: got %0d want 0", rd_plane); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
  endtask

  task automatic test_first_shift();
    logic exp_en, exp_clk;
    start_run(1'b0);
    run_n(1);
    total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL idle_rd_en: got %b want 0", rd_en); end
    enable = 1'b1;
    for (int n = 0; n < 130; n++) begin
      run_n(1);
      exp_en  = (n % 2 == 0) && (n < 128);
      exp_clk = (n % 2 == 1) && (n >= 3);
      total++; if (rd_en !== exp_en) begin bad++; $display("FAIL shift_rd_en[%0d]: got %b want %b", n, rd_en, exp_en); end
      if (exp_en) begin
        total++; if (rd_col !== 6'(n / 2)) begin bad++; $display("FAIL shift_rd_col[%0d]: got %0d want %0d", n, rd_col, n / 2); end
      end
      total++; if (hub75_clk !== exp_clk) begin bad++; $display("FAIL shift_sclk[%0d]: got %b want %b", n, hub75_clk, exp_clk); end
      total++; if (hub75_oe_ !== 1'b1) begin bad++; $display("FAIL shift_oe[%0d]: got %b want 1", n, hub75_oe_); end
      total++; if (hub75_lat !== 1'b0) begin bad++; $display("FAIL shift_lat[%0d]: got %b want 0", n, hub75_lat); end
      if (n % 2 == 1) rd_data = (((n - 1) / 2) % 2 == 0) ? 6'b101010 : 6'b010101;
    end
    run_n(1);
    total++; if (hub75_lat !== 1'b1) begin bad++; $display("FAIL latch_lat: got %b want 1", hub75_lat); end
    total++; if (hub75_row !== 3'd0) begin bad++; $display("FAIL latch_row: got %0d want 0", hub75_row); end
    total++; if (hub75_oe_ !== 1'b1) begin bad++; $display("FAIL latch_oe: got %b want 1", hub75_oe_); end
    total++; if (hub75_clk !== 1'b0) begin bad++; $display("FAIL latch_sclk: got %b want 0", hub75_clk); end
    total++; if (lat_rises !== 64) begin bad++; $display("FAIL sclk_rises: got %0d want 64", lat_rises); end
    total++; if (lt[5] !== 64'hAAAA_AAAA_AAAA_AAAA) begin bad++; $display("FAIL panel_r0: got %h want aaaaaaaaaaaaaaaa", lt[5]); end
    total++; if (lt[4] !== 64'h5555_5555_5555_5555) begin bad++; $display("FAIL panel_g0: got %h want 5555555555555555", lt[4]); end
    total++; if (lt[3] !== 64'hAAAA_AAAA_AAAA_AAAA) begin bad++; $display("FAIL panel_b0: got %h want aaaaaaaaaaaaaaaa", lt[3]); end
    total++; if (lt[2] !== 64'h5555_5555_5555_5555) begin bad++; $display("FAIL panel_r1: got %h want 5555555555555555", lt[2]); end
    total++; if (lt[1] !== 64'hAAAA_AAAA_AAAA_AAAA) begin bad++; $display("FAIL panel_g1: got %h want aaaaaaaaaaaaaaaa", lt[1]); end
    total++; if (lt[0] !== 64'h5555_5555_5555_5555) begin bad++; $display("FAIL panel_b1: got %h want 5555555555555555", lt[0]); end
    run_n(1);
    total++; if (hub75_oe_ !== 1'b0) begin bad++; $display("FAIL display_start_oe: got %b want 0", hub75_oe_); end
  endtask

  task automatic test_oe_widths();
    start_run(1'b1);
    run_n(2068);
    total++; if (lat_cnt !== 8) begin bad++; $display("FAIL lat_per_row: got %0d want 8", lat_cnt); end
    run_n(2069);
    total++; if (lat_cnt !== 16) begin bad++; $display("FAIL lat_two_rows: got %0d want 16", lat_cnt); end
    total++; if (widths.size() !== 16) begin bad++; $display("FAIL oe_width_count: got %0d want 16", widths.size()); end
    for (int i = 0; i < 16 && i < widths.size(); i++) begin
      total++; if (widths[i] !== (4 << (i % 8))) begin bad++; $display("FAIL oe_width[%0d]: got %0d want %0d", i, widths[i], 4 << (i % 8)); end
    end
  endtask

  task automatic test_frame();
    int s, t1, t2;
    start_run(1'b1);
    s  = 0;
    t1 = -1;
    while (s < 20000 && t1 < 0) begin
      run_n(1); s++;
      if (frame_done) t1 = s;
    end
    total++; if (t1 !== 16545) begin bad++; $display("FAIL frame_done_first: got sample %0d want 16545", t1); end
    total++; if (last_lat_row !== 3'd7) begin bad++; $display("FAIL frame_last_row: got %0d want 7", last_lat_row); end
    total++; if (rd_row !== 3'd0 || rd_plane !== 3'd0) begin bad++; $display("FAIL frame_wrap_pos: got row %0d plane %0d want 0 0", rd_row, rd_plane); end
    run_n(1); s++;
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL frame_done_width: got %b want 0", frame_done); end
    run_n(129); s += 129;
    total++; if (hub75_lat !== 1'b1 || hub75_row !== 3'd0) begin bad++; $display("FAIL frame_row_return: got lat %b row %0d want 1 0", hub75_lat, hub75_row); end
    t2 = -1;
    while (s < 40000 && t2 < 0) begin
      run_n(1); s++;
      if (frame_done) t2 = s;
    end
    total++; if (t2 - t1 !== 16544) begin bad++; $display("FAIL frame_period: got %0d want 16544", t2 - t1); end
  endtask

  task automatic test_enable_drop();
    start_run(1'b1);
    run_n(4601);
    total++; if (rd_row !== 3'd2 || rd_plane !== 3'd3) begin bad++; $display("FAIL drop_pos: got row %0d plane %0d want 2 3", rd_row, rd_plane); end
    enable = 1'b0;
    widths.delete();
    run_n(129);
    total++; if (widths.size() !== 1) begin bad++; $display("FAIL drop_display_count: got %0d want 1", widths.size()); end
    if (widths.size() > 0) begin
      total++; if (widths[0] !== 32) begin bad++; $display("FAIL drop_display_width: got %0d want 32", widths[0]); end
    end
    rd_en_cnt = 0;
    run_n(20);
    total++; if (rd_en_cnt !== 0) begin bad++; $display("FAIL idle_no_rd_en: got %0d want 0", rd_en_cnt); end
    total++; if (hub75_oe_ !== 1'b1 || oe_run !== 0) begin bad++; $display("FAIL idle_oe: got %b run %0d want 1 0", hub75_oe_, oe_run); end
    total++; if (widths.size() !== 1) begin bad++; $display("FAIL idle_no_display: got %0d want 1", widths.size()); end
    enable = 1'b1;
    run_n(1);
    total++; if (rd_en !== 1'b1 || rd_col !== 6'd0) begin bad++; $display("FAIL resume_rd: got en %b col %0d want 1 0", rd_en, rd_col); end
    total++; if (rd_row !== 3'd2 || rd_plane !== 3'd4) begin bad++; $display("FAIL resume_pos: got row %0d plane %0d want 2 4", rd_row, rd_plane); end
    run_n(199);
    total++; if (widths.size() !== 2) begin bad++; $display("FAIL resume_display_count: got %0d want 2", widths.size()); end
    if (widths.size() > 1) begin
      total++; if (widths[1] !== 64) begin bad++; $display("FAIL resume_display_width: got %0d want 64", widths[1]); end
    end
  endtask

  task automatic test_reset_mid_display();
    start_run(1'b1);
    run_n(2201);
    total++; if (hub75_oe_ !== 1'b0) begin bad++; $display("FAIL mid_display_oe: got %b want 0", hub75_oe_); end
    total++; if (rd_row !== 3'd1 || hub75_row !== 3'd1) begin bad++; $display("FAIL mid_display_row: got rd %0d panel %0d want 1 1", rd_row, hub75_row); end
    reset = 1'b1;
    #1;
    pv = {hub75_r0, hub75_g0, hub75_b0, hub75_r1, hub75_g1, hub75_b1};
    total++; if (hub75_oe_ !== 1'b1) begin bad++; $display("FAIL async_oe: got %b want 1", hub75_oe_); end
    total++; if (hub75_row !== 3'd0 || rd_row !== 3'd0) begin bad++; $display("FAIL async_rows: got panel %0d rd %0d want 0 0", hub75_row, rd_row); end
    total++; if (hub75_clk !== 1'b0 || hub75_lat !== 1'b0 || rd_en !== 1'b0 || frame_done !== 1'b0) begin bad++; $display("FAIL async_strobes: got clk %b lat %b rd_en %b fd %b want 0", hub75_clk, hub75_lat, rd_en, frame_done); end
    total++; if (rd_col !== 6'd0 || rd_plane !== 3'd0 || pv !== 6'd0) begin bad++; $display("FAIL async_fields: got col %0d plane %0d data %b want 0", rd_col, rd_plane, pv); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_n(1);
    total++; if (rd_en !== 1'b1) begin bad++; $display("FAIL restart_rd_en: got %b want 1", rd_en); end
    total++; if (rd_row !== 3'd0 || rd_plane !== 3'd0) begin bad++; $display("FAIL restart_pos: got row %0d plane %0d want 0 0", rd_row, rd_plane); end
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    rd_data = '0;
    test_reset();
    test_first_shift();
    test_oe_widths();
    test_frame();
    test_enable_drop();
    test_reset_mid_display();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
